// File: rtl/data_ram.sv
// data_ram: single-port synchronous RAM with a power-on/reset clear sweep.
// After reset the FSM writes zero to every word, one per cycle, and only then
// accepts requests. Reads have one cycle of latency.
// Optional feature macro: DATA_RAM_PARITY_EN stores an even-parity bit per
// word and reports a mismatch on read through parity_err.
//
// Handshake: there is no ready signal. A request (req=1) is taken on a rising
// edge only while busy=0; while busy=1 it is silently dropped. Each accepted
// read produces exactly one dout_valid pulse one cycle later, and dout and
// parity_err are meaningful only while dout_valid=1.
module data_ram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              busy,
  output logic              parity_err
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              dout_valid_q, dout_valid_d;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              accept;
  logic              rd_en;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;

  // Reset forces busy immediately, before the state register has reset.
  assign busy   = rst | (state_q == ST_CLEAR);
  assign accept = req & ~busy;
  assign rd_en  = accept & ~rw;

  // Next-state logic: sweep clr_cnt through every address, then park in IDLE.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    unique case (state_q)
      ST_CLEAR: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == {ADDR_W{1'b1}}) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_CLEAR;
      end
    endcase
  end

  // Single write port shared by the clear sweep and user writes; reset blocks both.
  always_comb begin
    we    = 1'b0;
    waddr = addr;
    wdata = din;
    if (!rst && state_q == ST_CLEAR) begin
      we    = 1'b1;
      waddr = clr_cnt_q;
      wdata = '0;
    end else if (accept && rw) begin
      we    = 1'b1;
      waddr = addr;
      wdata = din;
    end
  end

  // Read datapath: capture on an accepted read, otherwise hold the last value.
  always_comb begin
    dout_d       = dout_q;
    dout_valid_d = rd_en;
    if (rd_en) begin
      dout_d = mem_q[addr];
    end
  end

  // FSM and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_CLEAR;
      clr_cnt_q    <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  // Data array; not reset, contents survive rst until the sweep rewrites them.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;

`ifdef DATA_RAM_PARITY_EN
  logic par_q [DEPTH];
  logic parity_err_q, parity_err_d;

  // Error flag follows dout: recomputed on each read, held otherwise.
  always_comb begin
    parity_err_d = parity_err_q;
    if (rd_en) begin
      parity_err_d = ^{mem_q[addr], par_q[addr]};
    end
  end

  // Parity array written alongside the data array (even parity of the stored word).
  always_ff @(posedge clk) begin
    if (we) begin
      par_q[waddr] <= ^wdata;
    end
  end

  // Parity error register, reset with the other outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      parity_err_q <= 1'b0;
    end else begin
      parity_err_q <= parity_err_d;
    end
  end

  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_data_ram.sv
// tb_data_ram: scoreboard bench for data_ram with ADDR_W=4, DATA_W=8.
// Inputs change 1 ns after the rising edge; outputs are checked on the falling edge.
module tb_data_ram;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 2 ** ADDR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              req;
  logic              rw;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              busy;
  logic              parity_err;

  // Expected read results: {parity_err, dout}
  logic [DATA_W:0]   exp_q[$];
  logic [DATA_W-1:0] model_mem [DEPTH];
  logic              rd_pend = 1'b0;
  logic              exp_vld = 1'b0;
  int                n_cmp   = 0;
  int                n_err   = 0;

  data_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .rw         (rw),
    .addr       (addr),
    .din        (din),
    .dout       (dout),
    .dout_valid (dout_valid),
    .busy       (busy),
    .parity_err (parity_err)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected-valid pipeline: an accepted read shows dout_valid one cycle later.
  always @(posedge clk) exp_vld <= rd_pend;

  // Output monitor / scoreboard
  always @(negedge clk) begin
    logic [DATA_W:0] e;
    check("dout_valid", {63'd0, dout_valid}, {63'd0, exp_vld});
    if (dout_valid === 1'b1 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("dout", {56'd0, dout}, {56'd0, e[DATA_W-1:0]});
      check("parity_err", {63'd0, parity_err}, {63'd0, e[DATA_W]});
    end
  end

  // Driver tasks
  task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    @(posedge clk); #1;
    req = 1'b1; rw = 1'b1; addr = a; din = d; rd_pend = 1'b0;
    model_mem[a] = d;
  endtask

  task automatic rd(input logic [ADDR_W-1:0] a, input logic perr);
    @(posedge clk); #1;
    req = 1'b1; rw = 1'b0; addr = a; rd_pend = 1'b1;
    exp_q.push_back({perr, model_mem[a]});
  endtask

  task automatic idle();
    @(posedge clk); #1;
    req = 1'b0; rd_pend = 1'b0;
  endtask

  // Called right after rst falls: busy for exactly DEPTH cycles, then low.
  task automatic busy_window(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      check({tag, "_busy_hi"}, {63'd0, busy}, 64'd1);
    end
    @(negedge clk);
    check({tag, "_busy_lo"}, {63'd0, busy}, 64'd0);
    req = 1'b0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
  endtask

  initial begin
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rdat;
    logic              perr_exp;
    rst = 1'b1; req = 1'b1; rw = 1'b0; addr = '0; din = '0;

    // Reset for 3 cycles with a read held (must produce no dout_valid).
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", {63'd0, busy}, 64'd1);
    check("rst_dout", {56'd0, dout}, 64'd0);
    check("rst_perr", {63'd0, parity_err}, 64'd0);

    // Release reset with a write to 0x03 held during the sweep: it must be dropped.
    @(posedge clk); #1;
    rst = 1'b0; req = 1'b1; rw = 1'b1; addr = 4'h3; din = 8'hFF;
    busy_window("sweep1");

    // All words read back as zero, back to back.
    for (int i = 0; i < DEPTH; i++) rd(i[ADDR_W-1:0], 1'b0);
    idle();

    // Write then read next cycle.
    wr(4'h5, 8'hA5);
    rd(4'h5, 1'b0);
    idle();

    // Three consecutive reads of preloaded words.
    wr(4'h1, 8'h11);
    wr(4'h2, 8'h22);
    wr(4'h3, 8'h33);
    rd(4'h1, 1'b0);
    rd(4'h2, 1'b0);
    rd(4'h3, 1'b0);
    idle();
    idle();
    @(negedge clk);
    check("dout_hold", {56'd0, dout}, 64'h33);

    // Random mix of writes and reads.
    for (int i = 0; i < 40; i++) begin
      ra   = $urandom_range(0, DEPTH - 1);
      rdat = $urandom_range(0, 255);
      if ($urandom_range(0, 1) == 1) wr(ra, rdat);
      else rd(ra, 1'b0);
    end
    idle();

    // Corrupt the stored parity of 0x09 and read it back.
    wr(4'h9, 8'h3C);
    idle();
    perr_exp = 1'b0;
`ifdef DATA_RAM_PARITY_EN
    dut.par_q[9] = ~dut.par_q[9];
    perr_exp = 1'b1;
`endif
    rd(4'h9, perr_exp);
    idle();

    // Reset with a read in the same cycle, then a second reset at clr_cnt=7.
    wr(4'h5, 8'hA5);
    @(posedge clk); #1;
    rst = 1'b1; req = 1'b1; rw = 1'b0; addr = 4'h5; rd_pend = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; req = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    busy_window("sweep2");
    rd(4'h5, 1'b0);
    rd(4'h9, 1'b0);
    rd(4'h0, 1'b0);
    rd(4'hF, 1'b0);
    idle();
    idle();
    idle();

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/data_ram.md
DATA_RAM -- requirements
Module: data_ram

Interface
REQ-001: Parameter DATA_W, default 8, word width in bits (1..64).
REQ-002: Parameter ADDR_W, default 8, address width; depth = 2**ADDR_W words.
REQ-003: clk  input  1  single clock; all state updates on rising edge.
REQ-004: rst  input  1  synchronous, active-high reset.
REQ-005: req  input  1  access request; sampled only when busy=0.
REQ-006: rw  input  1  1=write, 0=read; qualified by req.
REQ-007: addr  input  ADDR_W  word address.
REQ-008: din  input  DATA_W  write data.
REQ-009: dout  output  DATA_W  registered read data.
REQ-010: dout_valid  output  1  one-cycle pulse; dout holds new read data.
REQ-011: busy  output  1  high during reset and the clear sweep; requests are ignored.
REQ-012: parity_err  output  1  parity mismatch on the current dout; qualified by dout_valid.

Function
REQ-013: FSM states CLEAR and IDLE; CLEAR->IDLE on the edge that writes the last address; IDLE has no exit except rst.
REQ-014: CLEAR writes zero (and the matching parity) to address clr_cnt each cycle; clr_cnt increments 0..2**ADDR_W-1.
REQ-015: The clear sweep takes exactly 2**ADDR_W cycles after rst falls; busy=0 from the following cycle.
REQ-016: req asserted while busy=1 is dropped: no write, no dout_valid, no error.
REQ-017: Write (IDLE, req=1, rw=1): mem[addr]<=din on that edge; dout unchanged; dout_valid=0.
REQ-018: Read (IDLE, req=1, rw=0): dout<=mem[addr] on that edge, giving 1-cycle latency; dout_valid=1 for exactly that following cycle.
REQ-019: Back-to-back reads are accepted every cycle; dout_valid stays high for consecutive accepted reads.
REQ-020: A read in the cycle after a write to the same address returns the newly written data.
REQ-021: dout holds its last read value when there is no read; dout_valid=0.
REQ-022: All addresses are in range (full power-of-two depth); there is no wrap or overflow case at the port.

Reset
REQ-023: While rst=1: state=CLEAR, clr_cnt=0, busy=1, dout=0, dout_valid=0, parity_err=0; memory contents are not altered.
REQ-024: rst asserted mid-sweep or mid-operation restarts the sweep from address 0 on the first edge after rst falls.
REQ-025: A read accepted in the cycle rst rises produces no dout_valid.

Configuration
REQ-026: Macro DATA_RAM_PARITY_EN defined: each word stores one extra even-parity bit computed from din (or from zero during clear).
REQ-027: With DATA_RAM_PARITY_EN, on a read parity_err<=(XOR of stored data and stored parity bit), registered alongside dout.
REQ-028: Without DATA_RAM_PARITY_EN: no parity storage; parity_err is constant 0.
REQ-029: Both builds have identical port lists, latency and FSM timing.

Verification
REQ-030: ADDR_W=4: rst high 3 cycles then low -> busy=1 for exactly 16 cycles, then 0; reading addr 0..15 gives dout=0 with dout_valid pulsed.
REQ-031: After clear: write addr=0x05 din=0xA5, then read 0x05 next cycle -> dout=0xA5, dout_valid=1 one cycle after the read request, parity_err=0.
REQ-032: req=1 rw=1 addr=0x03 din=0xFF while busy=1 -> after clear, read 0x03 returns 0x00.
REQ-033: Reads of 0x01, 0x02, 0x03 on three consecutive cycles (preloaded 0x11, 0x22, 0x33) -> dout=0x11, 0x22, 0x33 on the next three cycles, dout_valid high all three.
REQ-034: rst pulsed at clr_cnt=7 -> sweep restarts at 0; busy lasts a full 2**ADDR_W cycles after rst falls.
REQ-035: DATA_RAM_PARITY_EN: force-flip the stored parity bit of addr 0x09 via hierarchical reference, then read -> parity_err=1 with dout_valid=1; in the undefined build, parity_err stays 0.
